cg_memory_arbiter: RTL and testbench
====================================

CG_MEMORY_ARBITER -- requirements
Module: CG_memory_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, cycles allowed in any non-IDLE state before abort.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-005 Per requester x in {0,1}, it SHALL have these write ports: mx_wvalid in 1, mx_waddr in ADDR_WIDTH, mx_wdata in DATA_WIDTH, mx_wready out 1.
REQ-006 Per requester x, it SHALL have these read ports: mx_arvalid in 1, mx_araddr in ADDR_WIDTH, mx_arready out 1, mx_rvalid out 1, mx_rdata out DATA_WIDTH, mx_rready in 1.
REQ-007 Memory-side outputs SHALL be: s_wen, s_wvalid (1), s_waddr (ADDR_WIDTH), s_wdata (DATA_WIDTH), s_arvalid (1), s_araddr (ADDR_WIDTH), s_rready (1).
REQ-008 Memory-side inputs SHALL be: s_wready (1), s_arready (1), s_rvalid (1), s_rdata (DATA_WIDTH).
REQ-009 Status outputs SHALL be: busy out 1 (state != IDLE), grant_id out 1 (owning requester), timeout_err out 1 (one-cycle abort pulse).

Function
REQ-010 The FSM SHALL have states IDLE, WRITE, RADDR, RDATA, held in a register; memory-side and requester outputs SHALL be combinational from state, grant_id and the granted requester's inputs.
REQ-011 In IDLE, a requester SHALL be pending if its wvalid or arvalid is 1; with one pending requester it SHALL be granted; with both pending, the requester selected by the round-robin pointer rr SHALL be granted.
REQ-012 On grant, the next state SHALL be WRITE if the granted requester's wvalid=1, else RADDR (write-before-read within a requester); grant_id SHALL be registered with the state.
REQ-013 Grant-to-memory latency SHALL be exactly one cycle: request seen in IDLE at edge N, memory-side valid driven after edge N.
REQ-014 In WRITE: s_wen=s_wvalid=1, s_waddr/s_wdata = granted mx_waddr/mx_wdata; mx_wready = s_wready; on s_wready=1 -> IDLE.
REQ-015 In RADDR: s_arvalid=1, s_araddr = granted mx_araddr; mx_arready = s_arready; on s_arready=1 -> RDATA.
REQ-016 In RDATA: s_rready = granted mx_rready; mx_rvalid = s_rvalid; mx_rdata = s_rdata; on s_rvalid & mx_rready -> IDLE.
REQ-017 On every completed transaction, rr SHALL be set to the non-granted requester (~grant_id).
REQ-018 The non-granted requester SHALL see wready=arready=rvalid=0 and rdata=0; in IDLE both see all-zero outputs and all s_* outputs are 0.
REQ-019 A watchdog counter SHALL clear on entering any non-IDLE state and increment each cycle there; when it reaches TIMEOUT-1 without completion, the FSM SHALL go IDLE, pulse timeout_err for one cycle and update rr as a completion.
REQ-020 Completion in the same cycle as the timeout limit SHALL count as completion, with no timeout_err.
REQ-021 Requester inputs SHALL be held stable by the requester until its ready/rvalid handshake; the block SHALL NOT buffer addresses or data.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, rr=0, grant_id=0, watchdog=0, timeout_err=0, and therefore all outputs 0, including mid-transaction.
REQ-023 After rst_n deasserts, the first grant SHALL be evaluated at the next rising clk edge.

Verification
REQ-024 Single write: m0_wvalid=1, waddr=0x514, wdata=0x114, s_wready=1 -> s_wen=1, s_waddr=0x514 one cycle after the request, m0_wready pulses, busy falls next cycle.
REQ-025 Read after write: m1 reads 0x514, s_arready=1, s_rvalid=1 next cycle with s_rdata=0x114 -> m1_rvalid=1, m1_rdata=0x114, m0 outputs all 0.
REQ-026 Contention: both requesters assert wvalid at reset exit (0x515/0x214 and 0x516/0xAAAAAAAA) -> m0 is served first, then m1, and grant_id goes 0 then 1.
REQ-027 Same-requester write+read: m0 asserts wvalid (0x516/0x314) and arvalid (0x516) -> WRITE precedes RADDR, and the read returns 0x314.
REQ-028 Timeout: s_arready held 0 with TIMEOUT=16 -> timeout_err pulses after 16 cycles in RADDR, FSM returns to IDLE, rr flips.
REQ-029 Reset mid-RDATA: rst_n=0 while m0 is waiting for s_rvalid -> all outputs 0 asynchronously, and the first grant after release follows rr=0.

Source files
------------

// File: rtl/cg_memory_arbiter.sv
// cg_memory_arbiter
//   Two-requester arbiter in front of a single memory port. Each requester
//   can issue a write (wvalid/waddr/wdata) and/or a read (arvalid/araddr, then
//   rvalid/rdata). One transaction is in flight at a time. A requester that has
//   both a write and a read pending is served write first. Contention between
//   the two requesters is resolved by a round-robin pointer that moves to the
//   other requester after every completed (or aborted) transaction.
//   A per-state watchdog aborts a transaction that stalls for TIMEOUT cycles
//   and pulses timeout_err.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_wvalid/waddr/wdata      requester X write request (held until wready)
//   mX_wready                  requester X write accepted
//   mX_arvalid/araddr          requester X read request (held until arready)
//   mX_arready                 requester X read address accepted
//   mX_rvalid/rdata/rready     requester X read data handshake
//   s_wen/s_wvalid/s_waddr/s_wdata, s_wready      memory write channel
//   s_arvalid/s_araddr, s_arready                  memory read address channel
//   s_rvalid/s_rdata, s_rready                     memory read data channel
//   busy                       transaction in progress
//   grant_id                   requester owning the current transaction
//   timeout_err                one-cycle pulse after a watchdog abort
module cg_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  m0_wvalid,
  input  logic [ADDR_WIDTH-1:0] m0_waddr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_wready,
  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m0_rready,
  // requester 1
  input  logic                  m1_wvalid,
  input  logic [ADDR_WIDTH-1:0] m1_waddr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_wready,
  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic                  m1_rready,
  // memory side
  output logic                  s_wen,
  output logic                  s_wvalid,
  output logic [ADDR_WIDTH-1:0] s_waddr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_wready,
  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  s_rready,
  // status
  output logic                  busy,
  output logic                  grant_id,
  output logic                  timeout_err
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RADDR = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              gid_q, gid_d;
  logic              rr_q, rr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              terr_q, terr_d;

  // Inputs of the currently granted requester
  logic                  g_rready;
  logic [ADDR_WIDTH-1:0] g_waddr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [ADDR_WIDTH-1:0] g_araddr;

  // Arbitration helpers
  logic pend0, pend1;
  logic sel;
  logic sel_wvalid;
  logic done;
  logic stay;

  always_comb begin
    g_rready = gid_q ? m1_rready : m0_rready;
    g_waddr  = gid_q ? m1_waddr  : m0_waddr;
    g_wdata  = gid_q ? m1_wdata  : m0_wdata;
    g_araddr = gid_q ? m1_araddr : m0_araddr;
  end

  always_comb begin
    pend0      = m0_wvalid | m0_arvalid;
    pend1      = m1_wvalid | m1_arvalid;
    // Both pending: round-robin pointer decides; otherwise the lone requester.
    sel        = (pend0 & pend1) ? rr_q : pend1;
    sel_wvalid = sel ? m1_wvalid : m0_wvalid;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    terr_d  = 1'b0;
    done    = 1'b0;
    stay    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend0 | pend1) begin
          gid_d   = sel;
          state_d = sel_wvalid ? ST_WRITE : ST_RADDR;
          wd_d    = '0;
        end
      end
      ST_WRITE: begin
        if (s_wready) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else begin
          stay = 1'b1;
        end
      end
      ST_RADDR: begin
        if (s_arready) begin
          state_d = ST_RDATA;
          wd_d    = '0;
        end else begin
          stay = 1'b1;
        end
      end
      ST_RDATA: begin
        if (s_rvalid & g_rready) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else begin
          stay = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog only fires when the state makes no progress this cycle, so a
    // handshake landing on the limit cycle wins over the abort.
    if (stay) begin
      if (wd_q == WD_LIMIT) begin
        state_d = ST_IDLE;
        terr_d  = 1'b1;
        done    = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end

    if (done) begin
      rr_d = ~gid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gid_q   <= 1'b0;
      rr_q    <= 1'b0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
    end
  end

  // Output decode: everything is zero unless the state drives it, and only
  // the granted requester sees handshake signals.
  always_comb begin
    s_wen      = 1'b0;
    s_wvalid   = 1'b0;
    s_waddr    = '0;
    s_wdata    = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    m0_wready  = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_wready  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;

    unique case (state_q)
      ST_WRITE: begin
        s_wen    = 1'b1;
        s_wvalid = 1'b1;
        s_waddr  = g_waddr;
        s_wdata  = g_wdata;
        if (gid_q) m1_wready = s_wready;
        else       m0_wready = s_wready;
      end
      ST_RADDR: begin
        s_arvalid = 1'b1;
        s_araddr  = g_araddr;
        if (gid_q) m1_arready = s_arready;
        else       m0_arready = s_arready;
      end
      ST_RDATA: begin
        s_rready = g_rready;
        if (gid_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    grant_id    = gid_q;
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_cg_memory_arbiter.sv
// tb_cg_memory_arbiter
//   Directed bench: a cycle table of {inputs, expected outputs} followed by
//   hand-written sequences for watchdog abort, completion on the limit cycle,
//   and asynchronous reset in the middle of a read.
module tb_cg_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_wvalid, m0_arvalid, m0_rready;
  logic [31:0] m0_waddr, m0_wdata, m0_araddr;
  logic        m0_wready, m0_arready, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_wvalid, m1_arvalid, m1_rready;
  logic [31:0] m1_waddr, m1_wdata, m1_araddr;
  logic        m1_wready, m1_arready, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        s_wen, s_wvalid, s_arvalid, s_rready;
  logic [31:0] s_waddr, s_wdata, s_araddr;
  logic        s_wready, s_arready, s_rvalid;
  logic [31:0] s_rdata;
  logic        busy, grant_id, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cg_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_wvalid(m0_wvalid), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wready(m0_wready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m1_wvalid(m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wready(m1_wready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .s_wen(s_wen), .s_wvalid(s_wvalid), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wready(s_wready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [5:0]  req;     // {m1_rready,m1_arvalid,m1_wvalid,m0_rready,m0_arvalid,m0_wvalid}
    logic [31:0] a0, d0, a1, d1;
    logic [2:0]  mem;     // {s_rvalid,s_arready,s_wready}
    logic [31:0] rdata;
    logic [2:0]  e_st;    // {busy,grant_id,timeout_err}
    logic [2:0]  e_s;     // {s_wen&s_wvalid,s_arvalid,s_rready}
    logic [31:0] e_waddr, e_wdata, e_araddr;
    logic [5:0]  e_m;     // {m1_rvalid,m1_arready,m1_wready,m0_rvalid,m0_arready,m0_wready}
    logic [31:0] e_r0, e_r1;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  logic any_out;
  always_comb begin
    any_out = |{m0_wready, m0_arready, m0_rvalid, m0_rdata,
                m1_wready, m1_arready, m1_rvalid, m1_rdata,
                s_wen, s_wvalid, s_waddr, s_wdata, s_arvalid, s_araddr, s_rready,
                busy, grant_id, timeout_err};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_wvalid = 0; m0_arvalid = 0; m0_rready = 0;
    m0_waddr = '0; m0_wdata = '0; m0_araddr = '0;
    m1_wvalid = 0; m1_arvalid = 0; m1_rready = 0;
    m1_waddr = '0; m1_wdata = '0; m1_araddr = '0;
    s_wready = 0; s_arready = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    {m1_rready, m1_arvalid, m1_wvalid, m0_rready, m0_arvalid, m0_wvalid} = v.req;
    m0_waddr = v.a0; m0_araddr = v.a0; m0_wdata = v.d0;
    m1_waddr = v.a1; m1_araddr = v.a1; m1_wdata = v.d1;
    {s_rvalid, s_arready, s_wready} = v.mem;
    s_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d_status", idx), {29'd0, busy, grant_id, timeout_err}, {29'd0, v.e_st});
    chk($sformatf("v%0d_s_strobes", idx), {28'd0, s_wen, s_wvalid, s_arvalid, s_rready},
        {28'd0, v.e_s[2], v.e_s[2], v.e_s[1:0]});
    chk($sformatf("v%0d_s_waddr", idx), s_waddr, v.e_waddr);
    chk($sformatf("v%0d_s_wdata", idx), s_wdata, v.e_wdata);
    chk($sformatf("v%0d_s_araddr", idx), s_araddr, v.e_araddr);
    chk($sformatf("v%0d_m_strobes", idx),
        {26'd0, m1_rvalid, m1_arready, m1_wready, m0_rvalid, m0_arready, m0_wready}, {26'd0, v.e_m});
    chk($sformatf("v%0d_m0_rdata", idx), m0_rdata, v.e_r0);
    chk($sformatf("v%0d_m1_rdata", idx), m1_rdata, v.e_r1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // req, a0, d0, a1, d1, mem, rdata, e_st, e_s, e_waddr, e_wdata, e_araddr, e_m, e_r0, e_r1
    // single write by m0
    vecs[0]  = '{6'b000001, 32'h514, 32'h114, 32'h0, 32'h0, 3'b001, 32'h0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    vecs[1]  = '{6'b000001, 32'h514, 32'h114, 32'h0, 32'h0, 3'b001, 32'h0, 3'b100, 3'b100, 32'h514, 32'h114, 32'h0, 6'b000001, 32'h0, 32'h0};
    vecs[2]  = '{6'b000000, 32'h514, 32'h114, 32'h0, 32'h0, 3'b001, 32'h0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    // m1 reads back 0x514
    vecs[3]  = '{6'b110000, 32'h0, 32'h0, 32'h514, 32'h0, 3'b010, 32'h0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    vecs[4]  = '{6'b110000, 32'h0, 32'h0, 32'h514, 32'h0, 3'b010, 32'h0, 3'b110, 3'b010, 32'h0, 32'h0, 32'h514, 6'b010000, 32'h0, 32'h0};
    vecs[5]  = '{6'b100000, 32'h0, 32'h0, 32'h514, 32'h0, 3'b100, 32'h114, 3'b110, 3'b001, 32'h0, 32'h0, 32'h0, 6'b100000, 32'h0, 32'h114};
    vecs[6]  = '{6'b000000, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 3'b010, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    // m0 write+read to 0x516: write first
    vecs[7]  = '{6'b000111, 32'h516, 32'h314, 32'h0, 32'h0, 3'b001, 32'h0, 3'b010, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    vecs[8]  = '{6'b000111, 32'h516, 32'h314, 32'h0, 32'h0, 3'b001, 32'h0, 3'b100, 3'b100, 32'h516, 32'h314, 32'h0, 6'b000001, 32'h0, 32'h0};
    vecs[9]  = '{6'b000110, 32'h516, 32'h314, 32'h0, 32'h0, 3'b010, 32'h0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    vecs[10] = '{6'b000110, 32'h516, 32'h314, 32'h0, 32'h0, 3'b010, 32'h0, 3'b100, 3'b010, 32'h0, 32'h0, 32'h516, 6'b000010, 32'h0, 32'h0};
    vecs[11] = '{6'b000100, 32'h516, 32'h314, 32'h0, 32'h0, 3'b100, 32'h314, 3'b100, 3'b001, 32'h0, 32'h0, 32'h0, 6'b000100, 32'h314, 32'h0};
    vecs[12] = '{6'b000000, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    // m1 read with rready stalled one cycle
    vecs[13] = '{6'b010000, 32'h0, 32'h0, 32'h20, 32'h0, 3'b010, 32'h0, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};
    vecs[14] = '{6'b010000, 32'h0, 32'h0, 32'h20, 32'h0, 3'b010, 32'h0, 3'b110, 3'b010, 32'h0, 32'h0, 32'h20, 6'b010000, 32'h0, 32'h0};
    vecs[15] = '{6'b000000, 32'h0, 32'h0, 32'h20, 32'h0, 3'b100, 32'hDEAD, 3'b110, 3'b000, 32'h0, 32'h0, 32'h0, 6'b100000, 32'h0, 32'hDEAD};
    vecs[16] = '{6'b100000, 32'h0, 32'h0, 32'h20, 32'h0, 3'b100, 32'hDEAD, 3'b110, 3'b001, 32'h0, 32'h0, 32'h0, 6'b100000, 32'h0, 32'hDEAD};
    vecs[17] = '{6'b000000, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 32'h0, 3'b010, 3'b000, 32'h0, 32'h0, 32'h0, 6'b000000, 32'h0, 32'h0};

    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk); #1;
    chk("reset_outputs_zero", {31'd0, any_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Watchdog abort: m0 read stalls in RADDR (rr=0 here)
    @(negedge clk);
    clear_inputs();
    m0_arvalid = 1; m0_araddr = 32'h600;
    #1 chk("to_idle_before", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      chk($sformatf("to_raddr_busy_k%0d", k), {30'd0, busy, s_arvalid}, 32'd3);
      chk($sformatf("to_raddr_noerr_k%0d", k), {31'd0, timeout_err}, 32'd0);
    end
    @(negedge clk);
    m0_arvalid = 0;
    m0_wvalid = 1; m0_waddr = 32'h700; m0_wdata = 32'h1;
    m1_wvalid = 1; m1_waddr = 32'h710; m1_wdata = 32'h2;
    #1;
    chk("to_pulse", {30'd0, busy, timeout_err}, 32'd1);

    // Abort moved rr to m1: m1 wins contention; its write completes on the limit cycle
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      chk($sformatf("lim_wait_k%0d", k), {28'd0, busy, grant_id, timeout_err, m1_wready}, 32'b1100);
      if (k == 0) chk("lim_s_waddr", s_waddr, 32'h710);
    end
    @(negedge clk);
    s_wready = 1;
    #1;
    chk("lim_m1_wready", {31'd0, m1_wready}, 32'd1);
    chk("lim_s_wdata", s_wdata, 32'h2);
    @(negedge clk);
    m1_wvalid = 0;
    #1;
    chk("lim_no_timeout", {30'd0, busy, timeout_err}, 32'd0);
    @(negedge clk); #1;
    chk("lim_m0_next", {30'd0, grant_id, m0_wready}, 32'd1);
    chk("lim_m0_waddr", s_waddr, 32'h700);

    // Reset while m0 waits in RDATA (rr=1 here), then contention at reset exit
    @(negedge clk);
    m0_wvalid = 0; s_wready = 0;
    m0_arvalid = 1; m0_araddr = 32'h800; s_arready = 1;
    #1 chk("rst_pre_idle", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    chk("rst_pre_araddr", s_araddr, 32'h800);
    @(negedge clk);
    m0_arvalid = 0; s_arready = 0; m0_rready = 1;
    #1 chk("rst_pre_rdata", {29'd0, busy, s_rready, m0_rvalid}, 32'b110);
    @(negedge clk); #1;
    chk("rst_pre_still_waiting", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_zero", {31'd0, any_out}, 32'd0);
    m0_rready = 0;
    m0_wvalid = 1; m0_waddr = 32'h515; m0_wdata = 32'h214;
    m1_wvalid = 1; m1_waddr = 32'h516; m1_wdata = 32'hAAAAAAAA;
    s_wready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk($sformatf("rst_held_zero_k%0d", k), {31'd0, any_out}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("cont_first_gid_busy", {29'd0, busy, grant_id, timeout_err}, 32'b100);
    chk("cont_first_waddr", s_waddr, 32'h515);
    chk("cont_first_wdata", s_wdata, 32'h214);
    chk("cont_first_ready", {30'd0, m1_wready, m0_wready}, 32'b01);
    @(negedge clk);
    m0_wvalid = 0;
    #1 chk("cont_gap_idle", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    chk("cont_second_gid_busy", {29'd0, busy, grant_id, timeout_err}, 32'b110);
    chk("cont_second_waddr", s_waddr, 32'h516);
    chk("cont_second_wdata", s_wdata, 32'hAAAAAAAA);
    chk("cont_second_ready", {30'd0, m1_wready, m0_wready}, 32'b10);
    @(negedge clk);
    m1_wvalid = 0;
    #1 chk("cont_end_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
